// File: rtl/fifo_75x512_pkg.sv
// Shared constants and beat layout for the 75x512 user-data FIFO and the
// NWRITE/doorbell request generator that consumes it.
package fifo_75x512_pkg;

    localparam int DATA_W = 75;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = ADDR_W + 1;

    localparam int VALID_BIT = 74;
    localparam int FIRST_BIT = 73;
    localparam int KEEP_MSB  = 72;
    localparam int KEEP_LSB  = 65;
    localparam int LAST_BIT  = 64;
    localparam int DATA_MSB  = 63;

    typedef struct packed {
        logic        valid;
        logic        first;
        logic [7:0]  keep;
        logic        last;
        logic [63:0] data;
    } fifo_beat_t;

    function automatic logic [DATA_W-1:0] pack_beat(input fifo_beat_t beat);
        return beat;
    endfunction

endpackage

// File: rtl/sdp_ram_75x512.sv
// Simple dual-port 75x512 RAM: synchronous write port, registered read port
// with read enable. Written so synthesis maps it onto block RAM.
module sdp_ram_75x512
    import fifo_75x512_pkg::*;
(
    input  logic              log_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge log_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge log_clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_75x512_sync.sv
// Single-clock 75x512 standard-mode FIFO for user AXI-stream beats.
// Define FIFO_75X512_OVF_FLAGS_EN to add registered overflow/underflow pulses.
module fifo_75x512_sync
    import fifo_75x512_pkg::*;
(
    input  logic              log_clk,
    input  logic              log_rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] data_count
`ifdef FIFO_75X512_OVF_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_seen;
    logic [DATA_W-1:0] ram_rdata_p1;

    // Accepted operations; full/empty already exclude the illegal one when both are requested
    assign wr_acc = wr_en & ~full & ~log_rst;
    assign rd_acc = rd_en & ~empty & ~log_rst;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_seen <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr    <= rptr + 1'b1;
                rd_seen <= 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    assign data_count = count[ADDR_W-1:0];

    sdp_ram_75x512 u_ram (
        .log_clk (log_clk),
        .we      (wr_acc),
        .waddr   (wptr),
        .wdata   (din),
        .re      (rd_acc),
        .raddr   (rptr),
        .rdata   (ram_rdata_p1)
    );

    // --- read stage p1 ---
    // The block RAM output register has no async reset, so dout is forced to
    // zero until the first read after reset has reloaded it.
    assign dout = rd_seen ? ram_rdata_p1 : '0;

`ifdef FIFO_75X512_OVF_FLAGS_EN
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_75x512_sync.sv
// Directed self-checking bench for fifo_75x512_sync.
module tb_fifo_75x512_sync;
    import fifo_75x512_pkg::*;

    logic              log_clk = 1'b0;
    logic              log_rst = 1'b1;
    logic [DATA_W-1:0] din     = '0;
    logic              wr_en   = 1'b0;
    logic              rd_en   = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] data_count;
`ifdef FIFO_75X512_OVF_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    fifo_75x512_sync dut (
        .log_clk    (log_clk),
        .log_rst    (log_rst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .data_count (data_count)
`ifdef FIFO_75X512_OVF_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    always #5 log_clk = ~log_clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        din   = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] w1;
        w1 = 75'h1_0000_0000_0000_0000;

        // reset state
        repeat (3) tick();
        chk("rst_empty", 75'(empty), 75'(1));
        chk("rst_full", 75'(full), 75'(0));
        chk("rst_count", 75'(data_count), 75'(0));
        chk("rst_dout", dout, '0);
        log_rst = 1'b0;
        tick();

        // three writes, three reads
        push(w1 + 75'd1);
        chk("wr1_empty", 75'(empty), 75'(0));
        chk("wr1_count", 75'(data_count), 75'(1));
        push(w1 + 75'd2);
        push(w1 + 75'd3);
        chk("wr3_count", 75'(data_count), 75'(3));
        for (int i = 1; i <= 3; i++) begin
            pop();
            chk("rd3_dout", dout, w1 + 75'(i));
        end
        chk("rd3_empty", 75'(empty), 75'(1));
        tick();
        chk("dout_hold", dout, w1 + 75'd3);
        pop();
        chk("rd_empty_dout", dout, w1 + 75'd3);
        chk("rd_empty_count", 75'(data_count), 75'(0));
`ifdef FIFO_75X512_OVF_FLAGS_EN
        chk("underflow", 75'(underflow), 75'(1));
        tick();
        chk("underflow_clr", 75'(underflow), 75'(0));
`endif

        // fill to 512 (wraps pointers, which start at 3)
        for (int i = 0; i < DEPTH; i++) begin
            push(75'(i));
            if (i == 255) chk("fill_half", 75'(data_count), 75'(256));
        end
        chk("fill_full", 75'(full), 75'(1));
        chk("fill_count", 75'(data_count), 75'(0));
        chk("fill_empty", 75'(empty), 75'(0));
        push(75'h3e7);
        chk("ovf_full", 75'(full), 75'(1));
        chk("ovf_count", 75'(data_count), 75'(0));
`ifdef FIFO_75X512_OVF_FLAGS_EN
        chk("overflow", 75'(overflow), 75'(1));
`endif

        // simultaneous when full: oldest read, write dropped
        din   = 75'h3e8;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("simfull_dout", dout, 75'd0);
        chk("simfull_count", 75'(data_count), 75'(511));
        chk("simfull_full", 75'(full), 75'(0));
        for (int i = 1; i < DEPTH; i++) begin
            pop();
            chk("drain_dout", dout, 75'(i));
        end
        chk("drain_empty", 75'(empty), 75'(1));

        // steady state at count 5
        for (int k = 0; k < 5; k++) push(75'h100 + 75'(k));
        for (int j = 0; j < 10; j++) begin
            din   = 75'h105 + 75'(j);
            wr_en = 1'b1;
            rd_en = 1'b1;
            tick();
            chk("steady_dout", dout, 75'h100 + 75'(j));
            chk("steady_count", 75'(data_count), 75'(5));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pop();
            chk("steady_drain", dout, 75'h10a + 75'(k));
        end
        chk("steady_empty", 75'(empty), 75'(1));

        // simultaneous when empty: write lands, read ignored
        din   = 75'habc;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("simempty_dout", dout, 75'h10e);
        chk("simempty_count", 75'(data_count), 75'(1));
        chk("simempty_empty", 75'(empty), 75'(0));
        pop();
        chk("simempty_rd", dout, 75'habc);

        // async reset mid-cycle at count 100
        for (int i = 0; i < 101; i++) push(75'h2000 + 75'(i));
        pop();
        chk("pre_rst_dout", dout, 75'h2000);
        chk("pre_rst_count", 75'(data_count), 75'(100));
        #2;
        log_rst = 1'b1;
        #1;
        chk("arst_dout", dout, '0);
        chk("arst_empty", 75'(empty), 75'(1));
        chk("arst_count", 75'(data_count), 75'(0));
        din   = 75'h777;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("rst_wr_ign", 75'(data_count), 75'(0));
        log_rst = 1'b0;
        tick();
        push(75'h5a5a);
        chk("post_rst_count", 75'(data_count), 75'(1));
        pop();
        chk("post_rst_dout", dout, 75'h5a5a);
        chk("post_rst_empty", 75'(empty), 75'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
